// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with stall, flush and bubble insertion.
// Define PIPE_REG_SKID_EN to add a skid entry behind main with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned       CTRL_W   = 9,
    parameter int unsigned       DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

`ifdef PIPE_REG_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Registered ready: no combinational path from out_ready back upstream.
    assign in_ready  = !skid_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (skid_valid_q) begin
            if (out_ready) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_ready) begin
            main_valid_d = in_valid;
            if (in_valid) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_ctrl_d = CTRL_NOP;
            end
        end else if (in_valid) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end

        // Flush wins over any concurrent transfer; payload is left untouched.
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_NOP;
            main_data_d  = main_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = skid_ctrl_q;
            skid_data_d  = skid_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_NOP;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready  = !main_valid_q || out_ready;
    assign occupancy = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;

        if (in_ready) begin
            main_valid_d = in_valid;
            if (in_valid) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_ctrl_d = CTRL_NOP;
            end
        end

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_NOP;
            main_data_d  = main_data_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_NOP;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
        end
    end

endmodule
